pixel_sender: RTL and testbench
===============================

# pixel_sender

Pacing transmitter that feeds the line-buffer shift unit of the convolution datapath. It accepts pixels from an upstream valid/ready source into a small FIFO. It emits each pixel as a single-cycle `we` strobe with the byte on `data_store`, spaced by a programmable period. It also tracks pixel position within a frame and flags the last pixel.

## Interface
- `DATA_W`, 8: pixel width.
- `PERIOD`, 21: cycles between consecutive `we` rising edges; legal range 1 to 255.
- `FIFO_DEPTH`, 4: input buffer entries; must be a power of two, at least 2.
- `FRAME_PIX`, 49: pixels per frame; legal range 1 to 65535.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  level enable for emission.
- `in_valid`  in  1  upstream pixel valid.
- `in_data`  in  DATA_W  upstream pixel.
- `in_ready`  out  1  FIFO can accept; equals not-full.
- `we`  out  1  one-cycle write strobe to the shift unit.
- `data_store`  out  DATA_W  pixel for the shift unit; held between strobes.
- `frame_done`  out  1  one-cycle pulse, coincident with `we` of the last pixel of a frame.
- `busy`  out  1  high while FIFO non-empty or FSM not IDLE.

## Operation
- Push occurs when `in_valid && in_ready`. Push and pop in the same cycle leave the count unchanged. When full, `in_ready`=0, even if a pop occurs that cycle; there is no pass-through.
- "Eligible" means `start`=1 and the FIFO is non-empty.
- FSM states and transitions:
  - IDLE: if eligible, go to SEND.
  - SEND: `we`=1 for exactly one cycle and the head is popped. Then go to GAP if PERIOD>1. If PERIOD=1, stay in SEND when still eligible, otherwise go to IDLE.
  - GAP: the counter counts PERIOD-1 cycles. In the final GAP cycle, go to SEND if eligible, else go to IDLE.
- `data_store` loads the head in the same cycle `we` rises. It holds that value until the next strobe; it is never changed outside a strobe.
- Pixel counter:
  - Range is 0..FRAME_PIX-1; it increments on each strobe.
  - On the strobe where the count equals FRAME_PIX-1, `frame_done`=1 and the count wraps to 0.
- Dropping `start`:
  - No new strobe is issued.
  - A GAP in progress still runs to completion and then goes to IDLE.
  - The FIFO keeps accepting pixels.
  - The pixel counter is not cleared.
- Reset values:
  - `we`=0, `frame_done`=0, `data_store`=0, `busy`=0, `in_ready`=1.
  - FIFO empty, pixel count 0, FSM in IDLE, gap counter 0.
- Reset mid-operation: the state is aborted, buffered pixels are discarded, and all reset values apply on the cycle after the `rst` edge.

## Timing
- Latency from empty: a pixel pushed at edge E raises `we` at edge E+1 at the earliest, provided `start`=1 and the FSM is in IDLE.
- Sustained throughput: with `start` held high and the FIFO never empty, `we` rises exactly every PERIOD cycles. Each strobe is high for 1 cycle and low for PERIOD-1 cycles.
- After IDLE is re-entered: the next strobe comes no earlier than PERIOD cycles after the previous one. It comes 1 cycle after eligibility returns.
- `start` rising while in IDLE with a non-empty FIFO: `we` rises at the next edge.
- All outputs are registered. There is no combinational path from `in_valid` or `start` to `we` or `data_store`.
- `in_ready` is derived from the registered count only.

## Structure
- Shared package `conv_pkg`: the FSM state enum (IDLE, SEND, GAP) and the default `DATA_W` constant, reused by the shift unit.
- Sub-module `pix_fifo`: a synchronous FIFO parameterised by `DATA_W` and `FIFO_DEPTH`. It has push, pop, head, full and empty, with count-based full/empty.
- `pixel_sender` holds the FSM, the gap counter (width set by PERIOD) and the pixel counter (width set by FRAME_PIX).

## Test plan
- Reset: hold `rst` for 10 cycles. Required: `we`=0, `data_store`=0, `frame_done`=0, `busy`=0, `in_ready`=1; no strobe with `start`=0.
- Sequence: PERIOD=21, `start`=1; push ff, 0c, 1b, 2a, 6d, 88, 93 back-to-back (FIFO_DEPTH=4, so backpressure applies). Required:
  - 7 strobes exactly 21 cycles apart, values in push order.
  - `data_store` is held at 93 afterwards.
  - `busy` drops 20 cycles after the last strobe.
- Backpressure: `start`=0; offer 6 pixels. Required:
  - `in_ready`=0 after the 4th push, with no `we`.
  - Raise `start`: 4 buffered plus 2 remaining pixels are emitted in order; none is lost or duplicated.
- Frame: FRAME_PIX=3; stream 7 pixels. Required: `frame_done` coincides with strobes 3 and 6 only.
- Start gating: drop `start` mid-GAP after strobe 2 and hold it low for 50 cycles. Required:
  - No strobe while `start` is low.
  - After re-assert, the next strobe comes 1 cycle later, since more than PERIOD cycles have elapsed.
  - The pixel count continues, not restarted.
- Reset mid-GAP with 3 pixels buffered. Required:
  - All outputs at reset values on the next cycle; FIFO empty.
  - A fresh push then emits as pixel 0 of a new frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath front end.
// Holds the pacing FSM state encoding, the default pixel width and a
// small helper that sizes counters from their terminal value.
package conv_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_sender_if.sv
// Pixel stream bundle between the upstream source, the sender and the
// line-buffer shift unit.
//   in_valid/in_data/in_ready : upstream valid/ready pixel handshake
//   we/data_store             : single-cycle write strobe plus held pixel
//   frame_done                : pulse alongside the strobe of a frame's last pixel
// slave is the sender's view, master is the environment's view.
interface pixel_sender_if #(
    parameter int DATA_W = conv_pkg::DATA_W_DEF
) ();
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              we;
    logic [DATA_W-1:0] data_store;
    logic              frame_done;

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, data_store, frame_done
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, we, data_store, frame_done
    );
endinterface

// File: rtl/pix_fifo.sv
// Synchronous FIFO used as the sender's input buffer.
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write request and data (ignored when full)
//   pop       : read request (ignored when empty)
//   head      : oldest entry, valid while not empty
//   full/empty: derived from the registered occupancy count
module pix_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              push_ok, pop_ok;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pixel_sender.sv
// Pacing transmitter feeding the line-buffer shift unit. Buffers pixels
// from an upstream valid/ready source and emits one per PERIOD cycles as
// a single-cycle strobe, tracking position within a frame.
//   clk, rst : clock, synchronous active-high reset
//   start    : level enable for emission
//   bus      : pixel stream bundle (slave view)
//   busy     : FIFO holds data or a strobe/gap is in progress
module pixel_sender
    import conv_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PERIOD     = 21,
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_PIX  = 49
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    pixel_sender_if.slave  bus,
    output logic           busy
);
    localparam int GW = cnt_w(PERIOD);
    localparam int PW = cnt_w(FRAME_PIX);
    // GAP spans PERIOD-1 cycles; the counter runs down to zero.
    localparam logic [GW-1:0] GAP_LOAD = GW'((PERIOD > 1) ? PERIOD - 2 : 0);
    localparam logic [PW-1:0] PIX_LAST = PW'(FRAME_PIX - 1);

    state_t            state, next_state;
    logic [GW-1:0]     gap_cnt, gap_next;
    logic [PW-1:0]     pix_cnt;
    logic [DATA_W-1:0] head;
    logic              full, empty, eligible, pop;

    pix_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid && !full),
        .pop   (pop),
        .din   (bus.in_data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_ready = !full;
    assign eligible     = start && !empty;
    assign busy         = !empty || (state != IDLE);
    // The head leaves the FIFO on the edge that enters SEND, so the
    // strobe cycle already shows it on data_store.
    assign pop          = (next_state == SEND);

    always_comb begin
        next_state = state;
        gap_next   = gap_cnt;
        case (state)
            IDLE: if (eligible) next_state = SEND;
            SEND: begin
                if (PERIOD > 1) begin
                    next_state = GAP;
                    gap_next   = GAP_LOAD;
                end else if (!eligible) begin
                    next_state = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt == '0) next_state = eligible ? SEND : IDLE;
                else               gap_next   = gap_cnt - 1'b1;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            gap_cnt        <= '0;
            pix_cnt        <= '0;
            bus.we         <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.data_store <= '0;
        end else begin
            state          <= next_state;
            gap_cnt        <= gap_next;
            bus.we         <= pop;
            bus.frame_done <= pop && (pix_cnt == PIX_LAST);
            if (pop) begin
                bus.data_store <= head;
                pix_cnt        <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pixel_sender.sv
// Self-checking bench for pixel_sender. A queue-based reference model
// derives every strobe from the pacing rules: a strobe may occur at an
// edge when start is high, the buffer is non-empty and at least PERIOD
// cycles have passed since the previous strobe.
module tb_pixel_sender;
    localparam int PERIOD = 21;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 3;

    logic clk = 1'b0;
    logic rst, start, busy;
    int   n_vec = 0, n_err = 0;

    pixel_sender_if #(.DATA_W(8)) bus ();

    pixel_sender #(
        .DATA_W(8), .PERIOD(PERIOD), .FIFO_DEPTH(DEPTH), .FRAME_PIX(FRAME)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.slave), .busy(busy)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [7:0] mq[$];
    logic [7:0] pending[$];
    int         m_cnt = 0;
    longint     cyc = 0, ls = -1000;
    logic       m_we = 0, m_fd = 0, m_busy = 0, m_rdy = 1, m_pushed = 0;
    logic [7:0] m_ds = 0;
    bit         rnd_valid = 0;
    int         str_n = 0;
    int         fd_mask = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge();
        bit strobe, acc;
        cyc++;
        m_pushed = 0;
        if (rst) begin
            mq.delete();
            m_cnt = 0; ls = cyc - 1000;
            m_we = 0; m_fd = 0; m_ds = 0;
        end else begin
            strobe = start && (mq.size() > 0) && ((cyc - ls) >= PERIOD);
            acc    = bus.in_valid && (mq.size() < DEPTH);
            m_we = strobe; m_fd = 0;
            if (strobe) begin
                m_ds  = mq.pop_front();
                m_fd  = (m_cnt == FRAME - 1);
                m_cnt = (m_cnt + 1) % FRAME;
                ls    = cyc;
            end
            if (acc) mq.push_back(bus.in_data);
            m_pushed = acc;
        end
        m_rdy  = (mq.size() < DEPTH);
        m_busy = (mq.size() > 0) || ((cyc - ls) < PERIOD);
    endtask

    // One clock: drive inputs, advance the model, check at the falling edge.
    task automatic cyc1();
        bus.in_valid = (pending.size() > 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
        bus.in_data  = (pending.size() > 0) ? pending[0] : 8'($urandom);
        @(posedge clk);
        model_edge();
        if (m_pushed) void'(pending.pop_front());
        @(negedge clk);
        chk("we",         bus.we,         m_we);
        chk("data_store", bus.data_store, m_ds);
        chk("frame_done", bus.frame_done, m_fd);
        chk("busy",       busy,           m_busy);
        chk("in_ready",   bus.in_ready,   m_rdy);
        if (bus.we) begin
            str_n++;
            if (bus.frame_done) fd_mask |= (1 << str_n);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        pending.delete();
        repeat (n) cyc1();
        rst = 1'b0;
        str_n = 0; fd_mask = 0;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) pending.push_back(8'($urandom));
    endtask

    task automatic drain(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (pending.size() == 0 && !m_busy) break;
            cyc1();
        end
        if (i == limit) chk("drain_timeout", 32'(i), 32'(0));
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic wait_strobes(input int n, input int limit);
        int i;
        for (i = 0; i < limit && str_n < n; i++) cyc1();
        if (str_n < n) chk("strobe_timeout", 32'(str_n), 32'(n));
    endtask

    initial begin
        logic [7:0] seq [7] = '{8'hff, 8'h0c, 8'h1b, 8'h2a, 8'h6d, 8'h88, 8'h93};
        rst = 1'b1; start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0;

        // reset held 10 cycles, then idle with start low
        do_reset(10);
        chk("rst_ds",  bus.data_store, 8'h00);
        chk("rst_rdy", bus.in_ready,   1'b1);
        repeat (5) cyc1();

        // back-to-back push of a fixed sequence with start high
        start = 1'b1;
        foreach (seq[i]) pending.push_back(seq[i]);
        drain(400);
        chk("seq_strobes", 32'(str_n), 32'd7);
        chk("seq_hold",    bus.data_store, 8'h93);

        // backpressure with start low, then release
        do_reset(2);
        start = 1'b0;
        push_rand(6);
        repeat (12) cyc1();
        chk("bp_ready",   bus.in_ready, 1'b0);
        chk("bp_nostrobe", 32'(str_n), 32'd0);
        start = 1'b1;
        drain(400);
        chk("bp_strobes", 32'(str_n), 32'd6);

        // frame boundaries on strobes 3 and 6
        do_reset(2);
        push_rand(7);
        drain(400);
        chk("frame_mask", 32'(fd_mask), 32'h48);

        // start dropped mid-gap after strobe 2 for 50 cycles
        do_reset(2);
        push_rand(6);
        wait_strobes(2, 100);
        repeat (5) cyc1();
        start = 1'b0;
        repeat (50) cyc1();
        chk("gate_nostrobe", 32'(str_n), 32'd2);
        start = 1'b1;
        cyc1();
        chk("gate_resume", bus.we, 1'b1);
        drain(400);
        chk("gate_mask", 32'(fd_mask), 32'h48);

        // reset mid-gap with 3 pixels buffered, then a fresh frame
        do_reset(2);
        push_rand(4);
        wait_strobes(1, 100);
        repeat (5) cyc1();
        rst = 1'b1;
        pending.delete();
        cyc1();
        rst = 1'b0;
        chk("mid_rst_busy", busy,           1'b0);
        chk("mid_rst_ds",   bus.data_store, 8'h00);
        chk("mid_rst_rdy",  bus.in_ready,   1'b1);
        str_n = 0; fd_mask = 0;
        push_rand(3);
        drain(400);
        chk("mid_rst_frame", 32'(fd_mask), 32'h08);

        // randomized traffic, start toggling and occasional reset
        rnd_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (pending.size() < 3 && $urandom_range(0, 9) < 3) push_rand(1);
            if ($urandom_range(0, 39) == 0) start = ~start;
            rst = ($urandom_range(0, 299) == 0);
            if (rst) pending.delete();
            cyc1();
        end
        rst = 1'b0;
        start = 1'b1;
        drain(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
